draw_background_pattern: RTL
============================

# draw_background_pattern

Parametrised successor to the fixed-colour background stage. It sits directly after the VGA timing generator and ahead of the sprite/overlay stages. It passes the timing bus through a configurable-depth pipeline and draws a colour-bordered background. The background is selected per frame from four patterns: solid, checkerboard, colour bars and scrolling gradient. A frame counter drives the animation, and pattern changes take effect only at frame boundaries, which keeps frames tear-free.

## Interface
Parameters:
- H_ACTIVE, 800: active pixels per line; right border at H_ACTIVE-1.
- V_ACTIVE, 600: active lines; bottom border at V_ACTIVE-1.
- CW, 4: bits per colour channel; rgb width is 3*CW.
- PIPE, 1: pipeline depth in cycles, ≥1.
- TILE_LOG2, 5: checkerboard tile edge is 2^TILE_LOG2 pixels.
- BAR_LOG2, 7: colour bar width is 2^BAR_LOG2 pixels.
- BORDER_EN, 1: 1 draws the edge lines; 0 disables them.
- FILL_RGB, 12'h8_b_e: solid-fill colour and checker colour A.
- ALT_RGB, 12'h2_4_6: checker colour B.

Ports (clock and reset first):
- pclk  in  1  pixel clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- hcount_in, vcount_in  in  11 each  pixel position.
- hsync_in, hblnk_in, vsync_in, vblnk_in  in  1 each  timing.
- mode_in  in  2  requested pattern: 0 solid, 1 checker, 2 bars, 3 gradient.
- hcount_out, vcount_out  out  11 each  delayed copies of the inputs.
- hsync_out, hblnk_out, vsync_out, vblnk_out  out  1 each  delayed copies of the inputs.
- rgb_out  out  3*CW  pixel colour, aligned with the delayed timing outputs.
- frame_cnt  out  8  frame counter.

## Operation
- Frame start is the cycle where vblnk_in=1 and the registered previous vblnk_in=0.
- At frame start:
  - The active_mode register loads mode_in.
  - frame_cnt increments, wrapping 255 to 0.
  - A mode_in change at any other time has no effect until the next frame start.
- Colour is chosen by priority, evaluated on the input-stage values:
  1. hblnk_in or vblnk_in set: colour is 0.
  2. BORDER_EN=1 and vcount=0: yellow, R=G=all-ones, B=0.
  3. BORDER_EN=1 and vcount=V_ACTIVE-1: red.
  4. BORDER_EN=1 and hcount=0: green.
  5. BORDER_EN=1 and hcount=H_ACTIVE-1: blue.
  6. Otherwise the pattern for active_mode, as below.
- Mode 0 (solid): FILL_RGB.
- Mode 1 (checker): hcount[TILE_LOG2] XOR vcount[TILE_LOG2]. Result 0 gives FILL_RGB; result 1 gives ALT_RGB.
- Mode 2 (bars): index = hcount[BAR_LOG2+2:BAR_LOG2], so eight bars wrap modulo 8. Bars 0 to 7 are white, yellow, cyan, green, magenta, red, blue, black. Each channel is either all-ones or 0.
- Mode 3 (gradient): s = (hcount[7:0] + frame_cnt) mod 256, using 8-bit wrap.
  - R = s[7:8-CW]
  - G = vcount[7:8-CW]
  - B = frame_cnt[7:8-CW]
- The frame_cnt value used in mode 3 is the register value before the frame-start increment, so the whole frame sees a constant value.
- Timing signals are not modified. All seven timing signals and rgb pass through PIPE identical register stages.

## Timing
- Latency: every output equals the corresponding input, or the colour computed from it, exactly PIPE cycles later.
- The mode and frame_cnt update is visible on outputs from the first pixel of the following active frame.
- Reset, including when asserted mid-frame:
  - All pipeline stages, all outputs, frame_cnt, active_mode and the previous-vblnk register are cleared to 0 on the next edge.
  - For PIPE cycles after release, outputs drain zeros.
  - If vblnk_in is already 1 at the first cycle after reset, that does not count as a frame start (previous vblnk is 0 only after reset, so qualify with a one-cycle post-reset inhibit).
- Simultaneous frame start and mode_in change: the new mode_in is captured.
- Boundaries:
  - Coordinates at or beyond H_ACTIVE/V_ACTIVE are not drawn; blanking covers them.
  - hcount/vcount arithmetic is unsigned; no sign extension.

## Test plan
- Reset with PIPE=2: assert rst for 3 cycles mid-line -> all outputs are 0 on the edge after assertion; the 2 cycles after release output zeros; frame_cnt=0.
- Default parameters, mode 0, 800x600 frame -> pixel (0,0)=F_F_0, (400,599)=F_0_0, (0,300)=0_F_0, (799,300)=0_0_F, (400,300)=8_B_E; blanking is 0; outputs appear PIPE cycles after inputs.
- Mode 1 -> (10,10)=8_B_E, (40,10)=2_4_6, (40,40)=8_B_E.
- Mode 2 -> (130,100)=F_F_0, (900 mod wrap check: hcount 1030 in an extended frame)=bar 0 white, (770,100)=blue.
- Mode change mid-frame from 0 to 3 -> the remaining pixels stay 8_B_E. After the next vblnk rise, frame_cnt=1 and pixel (16,32) = R=1, G=2, B=0.
- Run 256 frames -> frame_cnt wraps to 0. With BORDER_EN=0, pixel (0,0) shows the pattern colour instead of yellow.

Source files
------------

// File: rtl/draw_background_pattern.sv
// Background stage: delays the VGA timing bus by PIPE cycles and paints a bordered,
// per-frame selectable pattern (solid, checker, colour bars, scrolling gradient).
module draw_background_pattern #(
    parameter int              H_ACTIVE  = 800,
    parameter int              V_ACTIVE  = 600,
    parameter int              CW        = 4,
    parameter int              PIPE      = 1,
    parameter int              TILE_LOG2 = 5,
    parameter int              BAR_LOG2  = 7,
    parameter bit              BORDER_EN = 1'b1,
    parameter logic [3*CW-1:0] FILL_RGB  = 12'h8_b_e,
    parameter logic [3*CW-1:0] ALT_RGB   = 12'h2_4_6
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic [10:0]     hcount_in,
    input  logic [10:0]     vcount_in,
    input  logic            hsync_in,
    input  logic            hblnk_in,
    input  logic            vsync_in,
    input  logic            vblnk_in,
    input  logic [1:0]      mode_in,
    output logic [10:0]     hcount_out,
    output logic [10:0]     vcount_out,
    output logic            hsync_out,
    output logic            hblnk_out,
    output logic            vsync_out,
    output logic            vblnk_out,
    output logic [3*CW-1:0] rgb_out,
    output logic [7:0]      frame_cnt
);
    localparam int RGB_W = 3 * CW;
    localparam int BUS_W = 11 + 11 + 4 + RGB_W;
    localparam logic [CW-1:0] ONES = '1;
    localparam logic [CW-1:0] ZERO = '0;
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_LAST = 11'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_GRAD  = 2'd3
    } mode_e;

    mode_e            active_mode_q, active_mode_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             vblnk_prev_q, vblnk_prev_d;
    logic             inhibit_q, inhibit_d;
    logic             frame_start;
    logic [RGB_W-1:0] rgb_d;
    logic [BUS_W-1:0] pipe_q [PIPE];
    logic [BUS_W-1:0] pipe_d [PIPE];

    // Bar order: white, yellow, cyan, green, magenta, red, blue, black (R,G,B on/off).
    function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
        logic [2:0] m;
        case (idx)
            3'd0:    m = 3'b111;
            3'd1:    m = 3'b110;
            3'd2:    m = 3'b011;
            3'd3:    m = 3'b010;
            3'd4:    m = 3'b101;
            3'd5:    m = 3'b100;
            3'd6:    m = 3'b001;
            default: m = 3'b000;
        endcase
        return {{CW{m[2]}}, {CW{m[1]}}, {CW{m[0]}}};
    endfunction

    function automatic logic [RGB_W-1:0] gradient(input logic [10:0] h, input logic [10:0] v,
                                                  input logic [7:0] fc);
        logic [7:0] s;
        s = h[7:0] + fc;
        return {s[7:8-CW], v[7:8-CW], fc[7:8-CW]};
    endfunction

    // The cycle right after reset cannot start a frame: prev vblnk is only a reset artefact there.
    always_comb begin
        frame_start   = vblnk_in && !vblnk_prev_q && !inhibit_q;
        vblnk_prev_d  = vblnk_in;
        inhibit_d     = 1'b0;
        active_mode_d = active_mode_q;
        frame_cnt_d   = frame_cnt_q;
        if (frame_start) begin
            active_mode_d = mode_e'(mode_in);
            frame_cnt_d   = frame_cnt_q + 8'd1;
        end
    end

    always_comb begin
        rgb_d = '0;
        if (hblnk_in || vblnk_in) begin
            rgb_d = '0;
        end else if (BORDER_EN && vcount_in == 11'd0) begin
            rgb_d = {ONES, ONES, ZERO};
        end else if (BORDER_EN && vcount_in == V_LAST) begin
            rgb_d = {ONES, ZERO, ZERO};
        end else if (BORDER_EN && hcount_in == 11'd0) begin
            rgb_d = {ZERO, ONES, ZERO};
        end else if (BORDER_EN && hcount_in == H_LAST) begin
            rgb_d = {ZERO, ZERO, ONES};
        end else begin
            case (active_mode_q)
                MODE_SOLID: rgb_d = FILL_RGB;
                MODE_CHECK: rgb_d = (hcount_in[TILE_LOG2] ^ vcount_in[TILE_LOG2]) ? ALT_RGB : FILL_RGB;
                MODE_BARS:  rgb_d = bar_colour(hcount_in[BAR_LOG2+2:BAR_LOG2]);
                default:    rgb_d = gradient(hcount_in, vcount_in, frame_cnt_q);
            endcase
        end
    end

    always_comb begin
        pipe_d[0] = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in, rgb_d};
        for (int i = 1; i < PIPE; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            active_mode_q <= MODE_SOLID;
            frame_cnt_q   <= 8'd0;
            vblnk_prev_q  <= 1'b0;
            inhibit_q     <= 1'b1;
        end else begin
            active_mode_q <= active_mode_d;
            frame_cnt_q   <= frame_cnt_d;
            vblnk_prev_q  <= vblnk_prev_d;
            inhibit_q     <= inhibit_d;
        end
    end

    always_ff @(posedge pclk) begin
        for (int i = 0; i < PIPE; i++) begin
            if (rst) begin
                pipe_q[i] <= '0;
            end else begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out} = pipe_q[PIPE-1];
    assign frame_cnt = frame_cnt_q;

endmodule
